// File: rtl/manchester_pkg.sv
// -----------------------------------------------------------------------------
// manchester_pkg
// Shared definitions for the Manchester line-coding blocks (escape stage,
// framer, serializer).
//   framer_state_e      : framer FSM states
//   *_SYMBOL_DEF        : default line symbols; ESCAPE_SYMBOL_DEF is the
//                         escape stage's escape byte
//   cnt_width()         : width of a counter that must reach max(a, b)
// -----------------------------------------------------------------------------
package manchester_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        SFD      = 3'd2,
        PAYLOAD  = 3'd3,
        GAP      = 3'd4
    } framer_state_e;

    localparam logic [7:0] PREAMBLE_SYMBOL_DEF = 8'h55;
    localparam logic [7:0] SFD_SYMBOL_DEF      = 8'hD5;
    localparam logic [7:0] ESCAPE_SYMBOL_DEF   = 8'hE5;

    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/manchester_axis_reg.sv
// -----------------------------------------------------------------------------
// manchester_axis_reg
// Registered AXI-Stream output stage. The whole beat (valid/data/last) is
// replaced only when adv is high; otherwise it holds, which keeps the beat
// stable while the sink back-pressures.
// Ports:
//   aclk, aresetn        : clock, asynchronous active-low reset
//   adv                  : load enable (caller computes !valid || ready)
//   load_valid/data/last : next beat to present
//   valid/data/last      : registered beat driven onto the stream
// -----------------------------------------------------------------------------
module manchester_axis_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  adv,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  last
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic                  last_q,  last_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (adv) begin
            valid_d = load_valid;
            data_d  = load_data;
            last_d  = load_last;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign last  = last_q;

endmodule

// File: rtl/manchester_framer.sv
// -----------------------------------------------------------------------------
// manchester_framer
// Wraps each escaped payload frame with PREAMBLE_LEN preamble bytes and one
// SFD byte, passes the payload through unchanged and inserts GAP_LEN idle
// cycles after every frame.
// Ports:
//   aclk, aresetn          : clock, asynchronous active-low reset
//   s_axis_*               : escaped payload stream (tdata/tvalid/tready/tlast)
//   m_axis_*               : framed stream to the serializer
//   frame_count            : frames completed on m_axis (only when
//                            MANCHESTER_FRAMER_FRAME_CNT_EN is defined)
// Handshake: a beat moves when tvalid && tready at a rising clock edge; once
// m_axis_tvalid is high, tvalid/tdata/tlast hold until m_axis_tready is seen.
// Optional feature macro: MANCHESTER_FRAMER_FRAME_CNT_EN.
// -----------------------------------------------------------------------------
module manchester_framer
    import manchester_pkg::*;
#(
    parameter int                    DATA_WIDTH      = 8,
    parameter int                    PREAMBLE_LEN    = 7,
    parameter logic [DATA_WIDTH-1:0] PREAMBLE_SYMBOL = DATA_WIDTH'(PREAMBLE_SYMBOL_DEF),
    parameter logic [DATA_WIDTH-1:0] SFD_SYMBOL      = DATA_WIDTH'(SFD_SYMBOL_DEF),
    parameter int                    GAP_LEN         = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
`ifdef MANCHESTER_FRAMER_FRAME_CNT_EN
    ,
    output logic [31:0]           frame_count
`endif
);

    localparam int CNT_W = cnt_width(PREAMBLE_LEN, GAP_LEN);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN);
    localparam logic [CNT_W-1:0] GAP_LAST = (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    framer_state_e         state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  adv;
    logic                  src_ready;
    logic                  ld_valid;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_last;

    // The output register may take a new beat when it is empty or its
    // current beat is being accepted this cycle.
    assign adv = !m_axis_tvalid || m_axis_tready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        src_ready = 1'b0;
        ld_valid  = 1'b0;
        ld_data   = '0;
        ld_last   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The waiting payload byte only triggers the preamble; it is
                // not consumed here.
                if (adv && s_axis_tvalid) begin
                    ld_valid = 1'b1;
                    ld_data  = PREAMBLE_SYMBOL;
                    cnt_d    = CNT_ONE;
                    state_d  = PREAMBLE;
                end
            end

            PREAMBLE: begin
                if (adv) begin
                    ld_valid = 1'b1;
                    if (cnt_q < PRE_LAST) begin
                        ld_data = PREAMBLE_SYMBOL;
                        cnt_d   = cnt_q + CNT_ONE;
                    end else begin
                        ld_data = SFD_SYMBOL;
                        state_d = SFD;
                    end
                end
            end

            // While the SFD sits in the output register the first payload
            // byte may already be taken, so SFD and payload run back to back.
            // With no source byte the register loads a bubble instead.
            SFD, PAYLOAD: begin
                src_ready = adv;
                if (adv) begin
                    state_d = PAYLOAD;
                    if (s_axis_tvalid) begin
                        ld_valid = 1'b1;
                        ld_data  = s_axis_tdata;
                        ld_last  = s_axis_tlast;
                        if (s_axis_tlast) begin
                            cnt_d   = '0;
                            state_d = (GAP_LEN == 0) ? IDLE : GAP;
                        end
                    end
                end
            end

            // adv stays low while the tlast byte is still held, so the count
            // only starts with the cycle that byte transfers; afterwards the
            // register is empty and every cycle counts.
            GAP: begin
                if (adv) begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s_axis_tready = src_ready;

    manchester_axis_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .adv        (adv),
        .load_valid (ld_valid),
        .load_data  (ld_data),
        .load_last  (ld_last),
        .valid      (m_axis_tvalid),
        .data       (m_axis_tdata),
        .last       (m_axis_tlast)
    );

`ifdef MANCHESTER_FRAMER_FRAME_CNT_EN
    logic [31:0] frame_count_q, frame_count_d;

    // Wraps naturally from 32'hFFFF_FFFF to 0.
    always_comb begin
        frame_count_d = frame_count_q;
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            frame_count_d = frame_count_q + 32'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frame_count_q <= '0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_manchester_framer.sv
// -----------------------------------------------------------------------------
// tb_manchester_framer
// Bench for manchester_framer with default parameters. Expected beats come
// from a frame-level model (PREAMBLE_LEN x 55, D5, payload with tlast on the
// final byte) kept in exp_q; one negedge process compares every m_axis
// transfer, beat stability under back-pressure, idle gap length, the phase in
// which s_axis_tready may be high and (with MANCHESTER_FRAMER_FRAME_CNT_EN)
// frame_count.
// -----------------------------------------------------------------------------
module tb_manchester_framer;
    import manchester_pkg::*;

    localparam int DW   = 8;
    localparam int PLEN = 7;
    localparam int GAP  = 4;

    // ---------------- clock / reset ----------------
    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic [DW-1:0] s_tdata  = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tlast  = 1'b0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;
`ifdef MANCHESTER_FRAMER_FRAME_CNT_EN
    logic [31:0]   m_fc;
`endif

    manchester_framer dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast)
`ifdef MANCHESTER_FRAMER_FRAME_CNT_EN
        ,
        .frame_count   (m_fc)
`endif
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];      // {tlast, tdata}
    logic [8:0] lg_beat[$];    // transfers seen, for directed checks
    int         lg_cyc[$];

    int         fo = 0;        // output frame index
    int         fs = 0;        // source frame index (tlast accepted)
    int         out_cnt = 0;   // beats transferred in current output frame
    int         gap_left = 0;
    int         frames_done = 0;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_beat = '0;
    int         ready_mode = 0; // 0 always ready, 1 toggle, 2 random

    logic [7:0] fb[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level model: what the line must carry for one payload frame.
    task automatic push_frame_model(input int len);
        for (int i = 0; i < PLEN; i++) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
        for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), fb[i]});
    endtask

    // ---------------- compare process ----------------
    always @(negedge aclk) begin
        if (!aresetn) begin
            exp_q.delete();
            fo = 0; fs = 0; out_cnt = 0; gap_left = 0; frames_done = 0;
            prev_stall = 1'b0;
        end else begin
`ifdef MANCHESTER_FRAMER_FRAME_CNT_EN
            check("frame_count", m_fc, 32'(frames_done));
`endif
            if (prev_stall) begin
                check("hold_valid", 32'(m_tvalid), 32'd1);
                check("hold_beat", 32'({m_tlast, m_tdata}), 32'(prev_beat));
            end
            if (gap_left > 0) begin
                check("gap_idle", 32'(m_tvalid), 32'd0);
                gap_left--;
            end
            // Source may only be taken once the frame's preamble has gone out
            // and before that frame's tlast byte has been taken.
            if (s_tready) check("s_tready_phase", 32'(fs == fo && out_cnt >= PLEN), 32'd1);
            if (s_tvalid && s_tready && s_tlast) fs++;
            if (m_tvalid && m_tready) begin
                lg_beat.push_back({m_tlast, m_tdata});
                lg_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_beat: got %0h expected none", {m_tlast, m_tdata});
                end else begin
                    check("beat", 32'({m_tlast, m_tdata}), 32'(exp_q.pop_front()));
                end
                if (m_tlast) begin
                    fo++; out_cnt = 0; gap_left = GAP; frames_done++;
                end else begin
                    out_cnt++;
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = {m_tlast, m_tdata};
        end
    end

    // ---------------- sink ready driver ----------------
    initial begin
        forever begin
            @(posedge aclk); #1;
            case (ready_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = ~m_tready;
                default: m_tready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // ---------------- source driver tasks ----------------
    task automatic send_byte(input logic [7:0] d, input logic l, input int idle);
        int waited;
        if (idle > 0) begin
            s_tvalid = 1'b0;
            repeat (idle) begin @(posedge aclk); #1; end
        end
        s_tvalid = 1'b1; s_tdata = d; s_tlast = l;
        waited = 0;
        forever begin
            @(negedge aclk);
            if (s_tready) break;
            waited++;
            if (waited > 500) begin
                checks++; errors++;
                $display("FAIL src_timeout: got no s_tready expected handshake within 500 cycles");
                break;
            end
        end
        @(posedge aclk); #1;
        s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    endtask

    task automatic send_frame(input int len, input int stall_idx, input int stall_len);
        push_frame_model(len);
        for (int i = 0; i < len; i++)
            send_byte(fb[i], (i == len - 1), (i == stall_idx) ? stall_len : 0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin @(posedge aclk); n++; end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
        end
        repeat (GAP + 3) @(posedge aclk);
        #1;
    endtask

    task automatic clear_log();
        lg_beat.delete();
        lg_cyc.delete();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got no end of test expected finish before 2ms");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int c0;
        int fc_before;
        int len;

        // reset state
        #22;
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tdata", 32'(m_tdata), 32'd0);
        check("rst_tlast", 32'(m_tlast), 32'd0);
        check("rst_s_tready", 32'(s_tready), 32'd0);
`ifdef MANCHESTER_FRAMER_FRAME_CNT_EN
        check("rst_frame_count", m_fc, 32'd0);
`endif
        @(posedge aclk); #1;
        aresetn = 1'b1;
        ready_mode = 0;
        repeat (3) @(posedge aclk);
        #1;

        // 1: basic frame, sink always ready
        clear_log();
        fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33;
        c0 = cyc;
        send_frame(3, -1, 0);
        wait_drain();
        check("t1_count", 32'(lg_beat.size()), 32'd11);
        check("t1_first_pre", 32'(lg_beat[0]), 32'h055);
        check("t1_last_pre", 32'(lg_beat[6]), 32'h055);
        check("t1_sfd", 32'(lg_beat[7]), 32'h0D5);
        check("t1_pay0", 32'(lg_beat[8]), 32'h011);
        check("t1_pay2_last", 32'(lg_beat[10]), 32'h133);
        check("t1_latency", 32'(lg_cyc[8] - c0), 32'd9);
        check("t1_contiguous", 32'(lg_cyc[10] - lg_cyc[0]), 32'd10);

        // 2: same frame, sink ready toggling
        ready_mode = 1;
        clear_log();
        send_frame(3, -1, 0);
        wait_drain();
        check("t2_count", 32'(lg_beat.size()), 32'd11);
        check("t2_sfd", 32'(lg_beat[7]), 32'h0D5);
        check("t2_pay1", 32'(lg_beat[9]), 32'h022);
        check("t2_pay2_last", 32'(lg_beat[10]), 32'h133);

        // 3: payload carrying SFD and escape symbols passes unchanged
        ready_mode = 0;
        repeat (2) @(posedge aclk);
        #1;
        clear_log();
        fb[0] = 8'hD5; fb[1] = 8'hE5;
        send_frame(2, -1, 0);
        wait_drain();
        check("t3_count", 32'(lg_beat.size()), 32'd10);
        check("t3_pay_sfd", 32'(lg_beat[8]), 32'h0D5);
        check("t3_pay_esc_last", 32'(lg_beat[9]), 32'h1E5);

        // 4: 3-cycle upstream stall before the third byte
        clear_log();
        fb[0] = 8'h01; fb[1] = 8'h02; fb[2] = 8'h03; fb[3] = 8'h04;
        send_frame(4, 2, 3);
        wait_drain();
        check("t4_count", 32'(lg_beat.size()), 32'd12);
        check("t4_bubbles", 32'(lg_cyc[11] - lg_cyc[8] - 3), 32'd3);
        check("t4_pay2", 32'(lg_beat[10]), 32'h003);

        // 5: back-to-back single-byte frames
        clear_log();
        fc_before = frames_done;
`ifdef MANCHESTER_FRAMER_FRAME_CNT_EN
        fc_before = int'(m_fc);
`endif
        fb[0] = 8'hA1;
        send_frame(1, -1, 0);
        fb[0] = 8'hB2;
        send_frame(1, -1, 0);
        wait_drain();
        check("t5_count", 32'(lg_beat.size()), 32'd18);
        check("t5_a_last", 32'(lg_beat[8]), 32'h1A1);
        check("t5_gap", 32'(lg_cyc[9] - lg_cyc[8]), 32'd5);
        check("t5_b_pre", 32'(lg_beat[9]), 32'h055);
        check("t5_b_last", 32'(lg_beat[17]), 32'h1B2);
`ifdef MANCHESTER_FRAMER_FRAME_CNT_EN
        check("t5_frame_count", m_fc - 32'(fc_before), 32'd2);
`endif

        // 6: reset during the third preamble byte
        clear_log();
        fb[0] = 8'h77;
        push_frame_model(1);
        c0 = cyc;
        s_tvalid = 1'b1; s_tdata = 8'h77; s_tlast = 1'b1;
        repeat (3) @(posedge aclk);
        #2;
        check("t6_pre3_shown", 32'({m_tvalid, m_tdata}), 32'h155);
        aresetn = 1'b0;
        #1;
        check("t6_async_drop", 32'(m_tvalid), 32'd0);
`ifdef MANCHESTER_FRAMER_FRAME_CNT_EN
        check("t6_frame_count", m_fc, 32'd0);
`endif
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        clear_log();
        push_frame_model(1);
        c0 = cyc;
        send_byte(8'h77, 1'b1, 0);
        wait_drain();
        check("t6_count", 32'(lg_beat.size()), 32'd9);
        check("t6_pre7", 32'(lg_beat[6]), 32'h055);
        check("t6_sfd", 32'(lg_beat[7]), 32'h0D5);
        check("t6_pay_last", 32'(lg_beat[8]), 32'h177);
        check("t6_latency", 32'(lg_cyc[8] - c0), 32'd9);

        // 7: randomized frames, stalls and back-pressure
        ready_mode = 2;
        for (int f = 0; f < 20; f++) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 3))
                    0:       fb[i] = 8'hD5;
                    1:       fb[i] = 8'hE5;
                    default: fb[i] = 8'($urandom_range(0, 255));
                endcase
            end
            push_frame_model(len);
            for (int i = 0; i < len; i++)
                send_byte(fb[i], (i == len - 1), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end
        wait_drain();
        check("t7_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
